// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: byte-serial multi-byte adder controller.
// Takes NBYTES operand byte pairs LSB-first and feeds each pair through an 8-bit
// adder core (A + B -> s0, c0, no carry-in). The inter-byte carry is folded in
// afterwards as an increment of s0. Each sum byte is registered onto a
// valid/ready stream, and out_last/C mark the most-significant byte.
// Optional feature macro: SERIAL_ADD_OVF_EN adds output V, the two's-complement
// overflow of the full-width sum, which is valid on the last beat only.
module serial_add_ctrl #(
   parameter int NBYTES = 4,
   parameter int CW     = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic       abort,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] S,
   output logic       out_last,
   output logic       C
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic       V
`endif
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            carry_q, carry_d;
   logic            out_valid_q, out_valid_d;
   logic [7:0]      s_q, s_d;
   logic            last_q, last_d;
   logic            c_q, c_d;
`ifdef SERIAL_ADD_OVF_EN
   logic            v_q, v_d;
   logic            ovf;
`endif

   logic [8:0]      core_sum;
   logic [7:0]      s0;
   logic            c0;
   logic            cin;
   logic [7:0]      sum_byte;
   logic            cout;
   logic            is_last;
   logic            accept;

   // 8-bit adder core: plain A + B, no carry-in.
   assign core_sum = {1'b0, A} + {1'b0, B};
   assign s0       = core_sum[7:0];
   assign c0       = core_sum[8];

   // Merge the carry from the previous byte as an increment of the core result.
   // The first byte of a transaction (IDLE) always uses cin = 0.
   assign cin      = (state_q == RUN) ? carry_q : 1'b0;
   assign sum_byte = s0 + {7'b0, cin};
   assign cout     = c0 | (cin & (s0 == 8'hFF));
   assign is_last  = (cnt_q == CW'(NBYTES - 1));

`ifdef SERIAL_ADD_OVF_EN
   // Signed overflow: the operand signs agree but the sum sign differs.
   assign ovf = (A[7] == B[7]) && (sum_byte[7] != A[7]);
`endif

   // The single output stage accepts a new byte whenever it is empty or is
   // being drained in the same cycle.
   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   assign out_valid = out_valid_q;
   assign S         = s_q;
   assign out_last  = last_q;
   assign C         = c_q;
`ifdef SERIAL_ADD_OVF_EN
   assign V         = v_q;
`endif

   // Next-state logic. Priority is abort, then a new accept (which also covers
   // a simultaneous drain), then a plain drain.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      out_valid_d = out_valid_q;
      s_d         = s_q;
      last_d      = last_q;
      c_d         = c_q;
`ifdef SERIAL_ADD_OVF_EN
      v_d         = v_q;
`endif
      if (abort) begin
         state_d     = IDLE;
         cnt_d       = '0;
         carry_d     = 1'b0;
         out_valid_d = 1'b0;
         last_d      = 1'b0;
         c_d         = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         v_d         = 1'b0;
`endif
      end else if (accept) begin
         out_valid_d = 1'b1;
         s_d         = sum_byte;
         last_d      = is_last;
         c_d         = is_last ? cout : 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         v_d         = is_last ? ovf : 1'b0;
`endif
         if (is_last) begin
            state_d = IDLE;
            cnt_d   = '0;
            carry_d = 1'b0;
         end else begin
            state_d = RUN;
            cnt_d   = cnt_q + CW'(1);
            carry_d = cout;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // State, counter, carry and output register, all cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         out_valid_q <= 1'b0;
         s_q         <= 8'h00;
         last_q      <= 1'b0;
         c_q         <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         v_q         <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         out_valid_q <= out_valid_d;
         s_q         <= s_d;
         last_q      <= last_d;
         c_q         <= c_d;
`ifdef SERIAL_ADD_OVF_EN
         v_q         <= v_d;
`endif
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: bench for serial_add_ctrl with NBYTES=4.
// Expected sum bytes, carry and overflow come from full-width arithmetic on the
// whole operands. Each transaction queues its expected beats, and a monitor
// pops one beat for every out_valid && out_ready handshake.
module tb_serial_add_ctrl;

   localparam int NB = 4;
   localparam int W  = NB * 8;

   typedef struct {
      logic [7:0] s;
      logic       last;
      logic       c;
      logic       v;
   } beat_t;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] A;
   logic [7:0] B;
   logic       abort;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] S;
   logic       out_last;
   logic       C;
`ifdef SERIAL_ADD_OVF_EN
   logic       V;
`endif

   int    compCnt = 0;
   int    failCnt = 0;
   int    cycCnt  = 0;
   beat_t sb[$];

   serial_add_ctrl #(.NBYTES(NB), .CW(4)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .A(A),
      .B(B),
      .abort(abort),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .S(S),
      .out_last(out_last),
      .C(C)
`ifdef SERIAL_ADD_OVF_EN
      ,
      .V(V)
`endif
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Counts rising edges so back-to-back throughput can be measured.
   always @(posedge clk) cycCnt <= cycCnt + 1;

   // Hard time limit so that a stuck run still terminates.
   initial begin
      #400000;
      $display("[TB] FAIL global_timeout: observed no finish, expected finish");
      $fatal(1, "[TB] time limit reached");
   end

   // One counted comparison. Mismatches are reported with tag, observed and expected values.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compCnt++;
      assert (obs === exp) else begin
         failCnt++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Each downstream handshake consumes the oldest expected beat and is compared with it.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         logic  have;
         beat_t e;
         have = (sb.size() != 0);
         checkOutput("beat_available", 32'(have), 32'd1);
         if (have) begin
            e = sb.pop_front();
            checkOutput("beat_S", 32'(S), 32'(e.s));
            checkOutput("beat_last", 32'(out_last), 32'(e.last));
            if (e.last) checkOutput("beat_C", 32'(C), 32'(e.c));
`ifdef SERIAL_ADD_OVF_EN
            if (e.last) checkOutput("beat_V", 32'(V), 32'(e.v));
`endif
         end
      end
   end

   // Drives one transaction byte by byte. An optional stall holds out_ready low
   // after the first beat. stopAt >= 0 cuts the transaction before that byte,
   // either with abort (stopKind 1) or with an asynchronous reset (stopKind 2).
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                input int stallCycles, input int stopAt, input int stopKind);
      logic [W:0] full;
      beat_t      bt;
      int         i;
      int         guard;
      int         nPush;
      logic       acc;
      logic       lastExp;
      full  = {1'b0, a} + {1'b0, b};
      nPush = (stopAt >= 0) ? stopAt : NB;
      for (int k = 0; k < nPush; k++) begin
         bt.last = (k == NB - 1);
         bt.s    = full[8*k +: 8];
         bt.c    = bt.last ? full[W] : 1'b0;
         bt.v    = bt.last ? ((a[W-1] == b[W-1]) && (full[W-1] != a[W-1])) : 1'b0;
         sb.push_back(bt);
      end
      i     = 0;
      guard = 0;
      while (i < NB) begin
         if (i == stopAt) begin
            if (stopKind == 1) begin
               abort    = 1'b1;
               in_valid = 1'b1;
               A        = a[8*i +: 8];
               B        = b[8*i +: 8];
               @(posedge clk); #1;
               checkOutput("abort_valid_drop", 32'(out_valid), 32'd0);
               checkOutput("abort_last_drop", 32'(out_last), 32'd0);
               checkOutput("abort_beats_drained", 32'(sb.size()), 32'd0);
               abort    = 1'b0;
               in_valid = 1'b0;
            end else begin
               rst_n    = 1'b0;
               in_valid = 1'b0;
               #2;
               checkOutput("midreset_valid", 32'(out_valid), 32'd0);
               checkOutput("midreset_S", 32'(S), 32'd0);
               checkOutput("midreset_last", 32'(out_last), 32'd0);
               checkOutput("midreset_C", 32'(C), 32'd0);
               checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
               #1;
               rst_n = 1'b1;
               @(posedge clk); #1;
            end
            sb.delete();
            return;
         end
         in_valid = 1'b1;
         A        = a[8*i +: 8];
         B        = b[8*i +: 8];
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         if (acc) begin
            lastExp = (i == NB - 1);
            checkOutput("latency_valid", 32'(out_valid), 32'd1);
            checkOutput("latency_S", 32'(S), 32'(full[8*i +: 8]));
            checkOutput("latency_last", 32'(out_last), 32'(lastExp));
            checkOutput("latency_C", 32'(C), lastExp ? 32'(full[W]) : 32'd0);
`ifdef SERIAL_ADD_OVF_EN
            checkOutput("latency_V", 32'(V),
                        lastExp ? 32'((a[W-1] == b[W-1]) && (full[W-1] != a[W-1])) : 32'd0);
`endif
            i++;
            if (i == 1 && stallCycles > 0) begin
               out_ready = 1'b0;
               A         = a[15:8];
               B         = b[15:8];
               repeat (stallCycles) begin
                  @(negedge clk);
                  checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
                  checkOutput("stall_valid", 32'(out_valid), 32'd1);
                  checkOutput("stall_S", 32'(S), 32'(full[7:0]));
                  @(posedge clk); #1;
               end
               out_ready = 1'b1;
            end
         end
         guard++;
         if (guard > 200) begin
            checkOutput("accept_timeout", 32'(i), 32'(NB));
            return;
         end
      end
   endtask

   // Directed scenarios first, then randomized transactions, then a final drain check.
   initial begin
      int          startCyc;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      abort     = 1'b0;
      out_ready = 1'b1;
      A         = 8'h00;
      B         = 8'h00;
      #12;
      checkOutput("reset_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_S", 32'(S), 32'd0);
      checkOutput("reset_last", 32'(out_last), 32'd0);
      checkOutput("reset_C", 32'(C), 32'd0);
      checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
`ifdef SERIAL_ADD_OVF_EN
      checkOutput("reset_V", 32'(V), 32'd0);
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;

      $display("[TB] basic add");
      applyStimulus(32'h12345678, 32'h55667788, 0, -1, 0);
      in_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end

      $display("[TB] carry ripple");
      applyStimulus(32'hFFFFFFFF, 32'h00000001, 0, -1, 0);
      in_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end

      $display("[TB] backpressure");
      applyStimulus(32'h89ABCDEF, 32'h13579BDF, 3, -1, 0);
      in_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end

      $display("[TB] back-to-back");
      startCyc = cycCnt;
      applyStimulus(32'hFFFFFFFF, 32'h00000001, 0, -1, 0);
      applyStimulus(32'h01020304, 32'h05060708, 0, -1, 0);
      checkOutput("b2b_cycles", 32'(cycCnt - startCyc), 32'd8);
      in_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end

      $display("[TB] abort");
      applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 2, 1);
      applyStimulus(32'h00000001, 32'h00000001, 0, -1, 0);
      in_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end

      $display("[TB] mid-transaction reset");
      applyStimulus(32'hFFFFFFFF, 32'h00000001, 0, 2, 2);
      applyStimulus(32'h0000FFFF, 32'h00000001, 0, -1, 0);
      in_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end

      $display("[TB] signed overflow");
      applyStimulus(32'h7FFFFFFF, 32'h00000001, 0, -1, 0);
      applyStimulus(32'h80000000, 32'h80000000, 0, -1, 0);
      in_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end

      $display("[TB] random");
      for (int r = 0; r < 30; r++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         if ($urandom_range(0, 3) == 0) rb = ~ra + W'($urandom_range(0, 2));
         applyStimulus(ra, rb, int'($urandom_range(0, 2)), -1, 0);
         if ($urandom_range(0, 1) == 1) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
      end

      in_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, failCnt);
      $finish;
   end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Byte-serial multi-byte adder controller; sits directly downstream of the 8-bit parallel-prefix adder core (A, B -> S, C; no carry-in).
- Streams NBYTES operand byte pairs LSB-first, applies the inter-byte carry by an increment step on the core's S/C outputs, and registers the sum bytes plus final carry onto a valid/ready output stream.
- Produces NBYTES*8-bit sums from the 8-bit core.

Parameters:
- NBYTES, 4, operand bytes per transaction (2..16); transaction width = 8*NBYTES bits.
- CW, 4, byte counter width; must satisfy 2^CW >= NBYTES.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand byte pair valid.
- in_ready  output  1  block can accept a byte pair this cycle.
- A  input  8  operand A byte.
- B  input  8  operand B byte.
- abort  input  1  synchronous flush of the current transaction.
- out_valid  output  1  registered sum byte valid.
- out_ready  input  1  downstream accepts the sum byte.
- S  output  8  registered sum byte.
- out_last  output  1  S is the most-significant byte of the transaction.
- C  output  1  final carry-out; meaningful only when out_valid && out_last, 0 otherwise.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, S=0, out_last=0, C=0, byte counter=0, carry register=0, state=IDLE. in_ready=1 is combinational from the reset state.
- in_ready = !out_valid || out_ready, so the output register is a single stage with pass-through backpressure. Input accept = in_valid && in_ready.
- Core use: A and B drive the 8-bit adder core combinationally, giving s0 and c0.
- Carry merge:
  - sum byte = s0 + cin (mod 256).
  - cout = c0 | (cin & (s0 == 8'hFF)).
  - cin = 0 on the first byte of every transaction, otherwise the carry register.
- Latency: one cycle. The byte accepted at edge k appears on S with out_valid=1 after edge k.
- States:
  - IDLE: counter=0. Accept -> RUN, or -> DONE if NBYTES==1 (illegal per the parameter range; not required).
  - RUN: on each accept, counter++ and carry register = cout. When the accepted byte has counter==NBYTES-1, set out_last=1, C=cout, clear counter and carry, and return to IDLE.
  - Back-to-back transactions: the first byte of the next transaction may be accepted in the cycle after the last byte, with no bubble.
- Output hold: while out_valid && !out_ready, S, out_last and C stay stable, and in_ready=0.
- Output clear: if out_valid && out_ready and there is no new accept, out_valid falls to 0 and S, out_last and C keep their values; C is forced to 0 when out_last=0.
- abort (sampled at clk):
  - Clears counter and carry, forces IDLE, and drops out_valid and out_last.
  - Any accept in the same cycle is discarded.
  - abort has priority over every other event.
- Simultaneous out_ready and new accept: the output register reloads the new byte; out_valid stays 1.
- Counter wraps only through the last-byte rule. Overflow beyond NBYTES-1 cannot occur.
- rst_n asserted mid-transaction: immediate return to reset values; the partial transaction is lost and no out_last is emitted.

Optional Feature:
- Macro SERIAL_ADD_OVF_EN.
- When defined, an added output port V (1 bit) carries the two's-complement overflow of the full NBYTES-byte sum, computed on the last byte:
  - V = (A[7] == B[7]) && (sum byte[7] != A[7]).
  - V is registered with S, valid only when out_valid && out_last, and 0 otherwise; reset value 0.
- When undefined, port V and its logic do not exist. All other behaviour is identical.

Test Plan:
- NBYTES=4, bytes LSB-first A=78,56,34,12 and B=88,77,66,55 (hex), out_ready=1 -> S=00,CE,9A,67; out_last on the 4th byte; C=0; each byte one cycle after its accept.
- Carry ripple: A=FF,FF,FF,FF and B=01,00,00,00 -> S=00,00,00,00; C=1 on the last byte; the increment path carries across every byte.
- Backpressure: out_ready held 0 for 3 cycles after the first output -> in_ready=0 and S stable for those 3 cycles; then completes with correct values and no lost or duplicated bytes.
- Back-to-back: two 4-byte transactions with in_valid held high -> 8 consecutive out_valid beats; the second transaction's first byte uses cin=0 even though the first ended with C=1.
- Abort after 2 of 4 bytes, then a new transaction 00000001 + 00000001 -> out_valid drops in the abort cycle; the new result is S=02,00,00,00 with C=0.
- SERIAL_ADD_OVF_EN defined: 7FFFFFFF + 00000001 -> V=1, C=0 on the last beat; FFFFFFFF + 00000001 -> V=0, C=1.
